// File: rtl/grid_draw_scheduler.sv
// grid_draw_scheduler
// Rebuilds the 40x30 cell bitmap once per game tick. The back buffer is
// cleared, every snake segment is drawn, then the food cell. The buffers swap
// only during vblank, so the pixel driver never shows a partial frame.
// The write port follows the current FSM cycle. Segment coordinates arrive one
// cycle after seg_rd_idx and are written in that same cycle.
module grid_draw_scheduler #(
  parameter int GRID_COLS = 40,
  parameter int GRID_ROWS = 30,
  parameter int MAX_SEGS  = 15
) (
  input  logic        clk_74a,
  input  logic        reset_n,
  input  logic        frame_req,
  input  logic [5:0]  seg_count,
  output logic [3:0]  seg_rd_idx,
  input  logic [5:0]  seg_x,
  input  logic [5:0]  seg_y,
  input  logic        food_valid,
  input  logic [5:0]  food_x,
  input  logic [5:0]  food_y,
  input  logic        vblank,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic        wr_data,
  output logic        buf_sel,
  output logic        busy,
  output logic        done,
  output logic        oob_err,
  output logic        req_dropped
);

  localparam logic [5:0]  COLS_L    = 6'(GRID_COLS);
  localparam logic [5:0]  ROWS_L    = 6'(GRID_ROWS);
  localparam logic [10:0] LAST_CELL = 11'(GRID_COLS * GRID_ROWS - 1);
  localparam logic [3:0]  MAX_N     = 4'(MAX_SEGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_FOOD,
    S_WAIT_VB,
    S_SWAP
  } state_t;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic [3:0]  idx_q;
  logic [3:0]  n_q;
  logic        food_v_q;
  logic [5:0]  food_x_q;
  logic [5:0]  food_y_q;
  logic        pending_q;
  logic        dropped_q;
  logic        busy_q;
  logic        done_q;
  logic        buf_q;
  logic        oob_q;

  logic [3:0]  n_d;
  logic [10:0] seg_cell_d;
  logic        seg_ok_d;
  logic [10:0] food_cell_d;
  logic        food_ok_d;
  logic        accept_d;
  logic        pending_d;
  logic        dropped_d;

  // The row stride of 40 is built from two shifts: y*32 + y*8 + x.
  function automatic logic [10:0] cell_of(input logic [5:0] x, input logic [5:0] y);
    logic [10:0] yw;
    yw = {5'd0, y};
    cell_of = (yw << 5) + (yw << 3) + {5'd0, x};
  endfunction

  function automatic logic in_grid(input logic [5:0] x, input logic [5:0] y);
    in_grid = (x < COLS_L) && (y < ROWS_L);
  endfunction

  // This block covers the segment clamp, the cell addresses and the request
  // bookkeeping for the pending and dropped flags.
  always_comb begin
    n_d         = (seg_count > {2'b00, MAX_N}) ? MAX_N : seg_count[3:0];
    seg_cell_d  = cell_of(seg_x, seg_y);
    seg_ok_d    = in_grid(seg_x, seg_y);
    food_cell_d = cell_of(food_x_q, food_y_q);
    food_ok_d   = in_grid(food_x_q, food_y_q);
    accept_d    = ((state_q == S_IDLE) || (state_q == S_SWAP)) && (frame_req || pending_q);
    pending_d   = pending_q;
    dropped_d   = dropped_q;
    if (accept_d) begin
      // A request that arrives together with SWAP while one is already queued becomes the next pending one.
      pending_d = (state_q == S_SWAP) && pending_q && frame_req;
    end else if (frame_req && busy_q) begin
      if (pending_q) begin
        dropped_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // The write port comes from the current state. An out-of-range cell still
  // uses its slot, but no write is issued for it.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 1'b0;
    wr_addr = 12'd0;
    case (state_q)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = {~buf_q, cnt_q};
      end
      S_DRAW: begin
        if ((cnt_q != 11'd0) && seg_ok_d) begin
          wr_en   = 1'b1;
          wr_data = 1'b1;
          wr_addr = {~buf_q, seg_cell_d};
        end
      end
      S_FOOD: begin
        if (food_ok_d) begin
          wr_en   = 1'b1;
          wr_data = 1'b1;
          wr_addr = {~buf_q, food_cell_d};
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // This is the sequencing FSM, together with its registered status outputs.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      idx_q     <= 4'd0;
      n_q       <= 4'd0;
      food_v_q  <= 1'b0;
      food_x_q  <= 6'd0;
      food_y_q  <= 6'd0;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      buf_q     <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
      if (accept_d) begin
        n_q      <= n_d;
        food_v_q <= food_valid;
        food_x_q <= food_x;
        food_y_q <= food_y;
        busy_q   <= 1'b1;
        cnt_q    <= 11'd0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (cnt_q == LAST_CELL) begin
            cnt_q <= 11'd0;
            idx_q <= 4'd0;
            if (n_q != 4'd0) begin
              state_q <= S_DRAW;
            end else if (food_v_q) begin
              state_q <= S_FOOD;
            end else begin
              state_q <= S_WAIT_VB;
            end
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        S_DRAW: begin
          // The read index leads the write slot by one cycle.
          if ((cnt_q != 11'd0) && !seg_ok_d) begin
            oob_q <= 1'b1;
          end
          if (cnt_q == {7'd0, n_q}) begin
            state_q <= food_v_q ? S_FOOD : S_WAIT_VB;
          end else begin
            cnt_q <= cnt_q + 11'd1;
            if ((cnt_q + 11'd1) < {7'd0, n_q}) begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_FOOD: begin
          if (!food_ok_d) begin
            oob_q <= 1'b1;
          end
          state_q <= S_WAIT_VB;
        end
        S_WAIT_VB: begin
          if (vblank) begin
            state_q <= S_SWAP;
            buf_q   <= ~buf_q;
            done_q  <= 1'b1;
          end
        end
        S_SWAP: begin
          if (accept_d) begin
            state_q <= S_CLEAR;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign seg_rd_idx  = idx_q;
  assign buf_sel     = buf_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign oob_err     = oob_q;
  assign req_dropped = dropped_q;

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// Testbench for grid_draw_scheduler: table vectors, hand sequences for
// pending/drop and mid-frame reset, then randomized frames against a model.
module tb_grid_draw_scheduler;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_req = 1'b0;
  logic [5:0]  seg_count = 6'd0;
  logic [3:0]  seg_rd_idx;
  logic [5:0]  seg_x = 6'd0;
  logic [5:0]  seg_y = 6'd0;
  logic        food_valid = 1'b0;
  logic [5:0]  food_x = 6'd0;
  logic [5:0]  food_y = 6'd0;
  logic        vblank = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic        wr_data;
  logic        buf_sel;
  logic        busy;
  logic        done;
  logic        oob_err;
  logic        req_dropped;

  always #5 clk_74a = ~clk_74a;

  grid_draw_scheduler dut (
    .clk_74a     (clk_74a),
    .reset_n     (reset_n),
    .frame_req   (frame_req),
    .seg_count   (seg_count),
    .seg_rd_idx  (seg_rd_idx),
    .seg_x       (seg_x),
    .seg_y       (seg_y),
    .food_valid  (food_valid),
    .food_x      (food_x),
    .food_y      (food_y),
    .vblank      (vblank),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .buf_sel     (buf_sel),
    .busy        (busy),
    .done        (done),
    .oob_err     (oob_err),
    .req_dropped (req_dropped)
  );

  // Segment table with a one-cycle read latency
  logic [5:0] tx [16];
  logic [5:0] ty [16];
  always @(posedge clk_74a) begin
    seg_x <= tx[seg_rd_idx];
    seg_y <= ty[seg_rd_idx];
  end

  // Write and done monitor
  logic [12:0] cap [$];
  int done_cnt;
  always @(negedge clk_74a) begin
    if (wr_en) cap.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
  end

  int n_vec = 0;
  int n_bad = 0;
  bit m_buf = 1'b0;
  bit m_oob = 1'b0;
  bit m_drop = 1'b0;
  logic [12:0] expq [$];

  typedef struct {
    int cnt; int fv; int fx; int fy;
    int sx; int sy; int dx;
    int ov_idx; int ov_x; int ov_y;
    int vb; int exp_ones; int exp_first; int exp_oob;
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the list of writes one rebuild must issue, in order
  function automatic void build_model(input int cnt, input bit fv, input int fx, input int fy);
    int n;
    bit bank;
    expq.delete();
    bank = ~m_buf;
    for (int c = 0; c < 1200; c++) expq.push_back({bank, 11'(c), 1'b0});
    n = (cnt > 15) ? 15 : cnt;
    for (int i = 0; i < n; i++) begin
      if (int'(tx[i]) < 40 && int'(ty[i]) < 30)
        expq.push_back({bank, 11'(int'(ty[i]) * 40 + int'(tx[i])), 1'b1});
      else
        m_oob = 1'b1;
    end
    if (fv) begin
      if (fx < 40 && fy < 30) expq.push_back({bank, 11'(fy * 40 + fx), 1'b1});
      else m_oob = 1'b1;
    end
  endfunction

  task automatic tick;
    @(posedge clk_74a);
    #1;
  endtask

  task automatic pulse_req(input int cnt, input int fv, input int fx, input int fy);
    frame_req  = 1'b1;
    seg_count  = 6'(cnt);
    food_valid = fv[0];
    food_x     = 6'(fx);
    food_y     = 6'(fy);
    tick;
    frame_req = 1'b0;
  endtask

  task automatic scramble;
    seg_count  = 6'($urandom);
    food_valid = 1'($urandom);
    food_x     = 6'($urandom);
    food_y     = 6'($urandom);
  endtask

  task automatic compare_writes(input string nm);
    int bad;
    int lim;
    bad = -1;
    chk({nm, "_count"}, cap.size(), expq.size());
    lim = (cap.size() < expq.size()) ? cap.size() : expq.size();
    n_vec++;
    for (int i = 0; i < lim; i++) begin
      if (cap[i] !== expq[i]) begin
        bad = i;
        break;
      end
    end
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s_seq write %0d: got addr %0d data %0d, expected addr %0d data %0d",
               nm, bad, cap[bad][12:1], cap[bad][0], expq[bad][12:1], expq[bad][0]);
    end
  endtask

  task automatic wait_done(input int vbmode);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (vbmode == 2) vblank = ($urandom_range(0, 7) == 0);
      else if (vbmode == 1) vblank = 1'b1;
      tick;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) chk("swap_in_vblank", int'(vblank), 1);
    else begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done, expected done within 4000 cycles");
    end
  endtask

  task automatic run_frame(input int cnt, input int fv, input int fx, input int fy,
                           input int vbmode, output int ones, output int fst);
    cap.delete();
    done_cnt = 0;
    build_model(cnt, fv != 0, fx, fy);
    pulse_req(cnt, fv, fx, fy);
    scramble;
    chk("busy_after_accept", int'(busy), 1);
    wait_done(vbmode);
    m_buf = ~m_buf;
    tick;
    chk("busy_drop", int'(busy), 0);
    tick;
    compare_writes("frame");
    chk("buf_sel", int'(buf_sel), int'(m_buf));
    chk("done_pulses", done_cnt, 1);
    chk("oob_err", int'(oob_err), int'(m_oob));
    chk("req_dropped", int'(req_dropped), int'(m_drop));
    ones = 0;
    fst = -1;
    foreach (cap[i]) begin
      if (cap[i][0]) begin
        if (fst < 0) fst = int'(cap[i][11:1]);
        ones++;
      end
    end
  endtask

  initial begin
    int ones;
    int fst;
    int got;

    for (int i = 0; i < 16; i++) begin
      tx[i] = 6'd0;
      ty[i] = 6'd0;
    end
    done_cnt = 0;

    vt[0] = '{cnt:5, fv:1, fx:3, fy:4, sx:20, sy:15, dx:1, ov_idx:-1, ov_x:0, ov_y:0,
              vb:1, exp_ones:6, exp_first:620, exp_oob:0};
    vt[1] = '{cnt:0, fv:0, fx:0, fy:0, sx:0, sy:0, dx:1, ov_idx:-1, ov_x:0, ov_y:0,
              vb:2, exp_ones:0, exp_first:-1, exp_oob:0};
    vt[2] = '{cnt:40, fv:0, fx:0, fy:0, sx:0, sy:1, dx:1, ov_idx:-1, ov_x:0, ov_y:0,
              vb:2, exp_ones:15, exp_first:40, exp_oob:0};
    vt[3] = '{cnt:3, fv:1, fx:7, fy:7, sx:10, sy:2, dx:1, ov_idx:1, ov_x:40, ov_y:2,
              vb:1, exp_ones:3, exp_first:90, exp_oob:1};

    // Reset state
    repeat (3) tick;
    chk("reset_outs_held", int'({wr_en, wr_addr, wr_data, buf_sel, busy, done, oob_err, req_dropped, seg_rd_idx}), 0);
    reset_n = 1'b1;
    tick;
    chk("reset_outs_released", int'({wr_en, wr_addr, wr_data, buf_sel, busy, done, oob_err, req_dropped, seg_rd_idx}), 0);

    // Table-driven frames
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) begin
        tx[i] = 6'(vt[v].sx + i * vt[v].dx);
        ty[i] = 6'(vt[v].sy);
        if (i == vt[v].ov_idx) begin
          tx[i] = 6'(vt[v].ov_x);
          ty[i] = 6'(vt[v].ov_y);
        end
      end
      run_frame(vt[v].cnt, vt[v].fv, vt[v].fx, vt[v].fy, vt[v].vb, ones, fst);
      chk("vec_ones", ones, vt[v].exp_ones);
      chk("vec_first_one", fst, vt[v].exp_first);
      chk("vec_oob", int'(oob_err), vt[v].exp_oob);
    end

    // Pending and dropped requests, with swap held off by a low vblank
    for (int i = 0; i < 16; i++) begin
      tx[i] = 6'(i + 1);
      ty[i] = 6'd1;
    end
    vblank = 1'b0;
    cap.delete();
    done_cnt = 0;
    build_model(2, 1'b0, 0, 0);
    pulse_req(2, 0, 0, 0);
    repeat (10) tick;
    pulse_req(1, 1, 5, 5);
    chk("pending_no_drop", int'(req_dropped), int'(m_drop));
    repeat (5) tick;
    pulse_req(1, 1, 5, 5);
    m_drop = 1'b1;
    chk("req_dropped_set", int'(req_dropped), 1);
    got = 0;
    for (int k = 0; k < 2000; k++) begin
      if (cap.size() >= expq.size()) begin
        got = 1;
        break;
      end
      tick;
    end
    chk("pend_writes_seen", got, 1);
    repeat (20) tick;
    chk("wait_vb_busy", int'(busy), 1);
    chk("wait_vb_buf_sel", int'(buf_sel), int'(m_buf));
    chk("wait_vb_no_done", done_cnt, 0);
    chk("wait_vb_no_write", int'(wr_en), 0);
    compare_writes("pend_first");
    wait_done(1);
    m_buf = ~m_buf;
    cap.delete();
    build_model(1, 1'b1, 5, 5);
    tick;
    chk("restart_busy", int'(busy), 1);
    chk("restart_write", int'(wr_en), 1);
    wait_done(1);
    m_buf = ~m_buf;
    tick;
    chk("pend_busy_drop", int'(busy), 0);
    tick;
    compare_writes("pend_second");
    chk("pend_buf_sel", int'(buf_sel), int'(m_buf));
    chk("pend_done_pulses", done_cnt, 2);
    chk("pend_dropped_sticky", int'(req_dropped), 1);

    // Reset in the middle of the segment draw
    for (int i = 0; i < 16; i++) begin
      tx[i] = 6'(i + 5);
      ty[i] = 6'd20;
    end
    vblank = 1'b0;
    pulse_req(10, 1, 1, 1);
    got = 0;
    for (int k = 0; k < 1500; k++) begin
      tick;
      if (wr_en && wr_data) begin
        got = 1;
        break;
      end
    end
    chk("draw_reached", got, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_buf_sel", int'(buf_sel), 0);
    chk("abort_flags", int'({oob_err, req_dropped, done}), 0);
    m_buf = 1'b0;
    m_oob = 1'b0;
    m_drop = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    run_frame(10, 1, 1, 1, 1, ones, fst);
    chk("post_reset_ones", ones, 11);

    // Randomized frames
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < 16; i++) begin
        tx[i] = 6'($urandom_range(0, 44));
        ty[i] = 6'($urandom_range(0, 33));
      end
      run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 44)), int'($urandom_range(0, 33)), 2, ones, fst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
